axi4_ram_slave: RTL and testbench
=================================

// Module: axi4_ram_slave
// PURPOSE
//  Parametrised AXI4 RAM slave that serves the vex_soc m00 AXI master as main memory in simulation and on FPGA.
//  Supports INCR, FIXED and WRAP bursts, byte strobes, and independent read/write channels.
//  Out-of-range accesses return SLVERR.
//  Optional preload from a hex file.
// PARAMETERS
//  DATA_WIDTH  32        data bus width, bits; 32/64/128
//  ADDR_WIDTH  32        byte-address width
//  ID_WIDTH    4         AXI ID width
//  DEPTH       4096      RAM size in DATA_WIDTH words
//  INIT_FILE   ""        $readmemh preload; empty = contents undefined
// PORTS
//  clk                              in   1           single clock, rising edge
//  reset                            in   1           synchronous, active-high
//  s_axi_awid / s_axi_arid          in   ID_WIDTH    write / read transaction ID
//  s_axi_awaddr / s_axi_araddr      in   ADDR_WIDTH  burst start byte address
//  s_axi_awlen / s_axi_arlen        in   8           beats-1
//  s_axi_awburst / s_axi_arburst    in   2           0=FIXED 1=INCR 2=WRAP
//  s_axi_wdata                      in   DATA_WIDTH  write data
//  s_axi_wstrb                      in   DATA_WIDTH/8  byte enables
//  s_axi_wlast                      in   1           ignored; burst length comes from awlen
//  s_axi_awvalid,wvalid,bready,arvalid,rready  in  1  handshake inputs
//  s_axi_awready,wready,bvalid,arready,rvalid  out 1  handshake outputs
//  s_axi_bid / s_axi_rid            out  ID_WIDTH    echo of latched awid / arid
//  s_axi_bresp / s_axi_rresp        out  2           0=OKAY, 2=SLVERR
//  s_axi_rdata                      out  DATA_WIDTH  read data
//  s_axi_rlast                      out  1           final read beat
// BEHAVIOUR
//  Reset values: all outputs 0; FSMs go to IDLE. awready/arready rise the first cycle after reset deasserts.
//  Beat size: fixed at full width, BYTES=DATA_WIDTH/8. widx = addr[ADDR_WIDTH-1:log2(BYTES)].
//  In-range condition: widx<DEPTH. Low address bits are ignored.
//  Address step per beat:
//   - FIXED: no change.
//   - INCR: +BYTES.
//   - WRAP: +BYTES, wrapping within aligned (len+1)*BYTES window; len must be 1/3/7/15, other values treated as INCR.
//  Write FSM:
//   - W_IDLE: awready=1. AW handshake latches id/addr/len/burst, clears err flag -> W_DATA.
//   - W_DATA: awready=0, wready=1. Each W handshake writes strobed bytes if in range, else sets err.
//     Beat counter==len -> W_RESP (wready drops next cycle).
//   - W_RESP: bvalid=1, bresp=err?2:0, bid=latched id. Held stable until bready -> W_IDLE.
//  Read FSM:
//   - R_IDLE: arready=1. AR handshake latches fields -> R_DATA.
//     rvalid rises next cycle with beat 0 (latency 1 from AR handshake).
//   - R_DATA: rdata/rresp/rlast/rid held stable while rvalid&&!rready.
//     On handshake the next beat loads the same cycle, so rready held high gives 1 beat/clock.
//     rlast=1 on beat len. Handshake on rlast -> R_IDLE, rvalid=0.
//   - Out-of-range beat: rdata=0, rresp=2; burst continues to completion.
//  Channels are fully independent: one outstanding write and one outstanding read at a time.
//  Same-cycle read and write to the same word: read returns old data (read-first).
//  Reset mid-burst: FSMs to IDLE next edge, valid outputs 0, burst abandoned. Beats already written remain; RAM is never cleared by reset.
// TESTING
//  Write 0xDEADBEEF @0x10, wstrb=F, then read 0x10 -> bresp=0, rdata=0xDEADBEEF, rlast=1, rresp=0.
//  INCR len=3 write @0x20 (1,2,3,4); read with rready toggling 1/0 -> beats 1,2,3,4 in order, rdata stable across stalls, rlast on 4th.
//  WRAP len=3 @0x38 -> beats at 0x38,0x3C,0x30,0x34; readback matches.
//  Word = 0xFFFFFFFF; write 0x11223344 with wstrb=4'b0101 -> reads 0xFF22FF44.
//  Access @DEPTH*BYTES -> bresp=2; rresp=2, rdata=0; word 0 unchanged.
//  Assert reset during read beat 2 of len=7 burst -> rvalid=0 next cycle; arready=1 one cycle after release; new read correct.

Source files
------------

// File: rtl/axi4_ram_slave.sv
// axi4_ram_slave: AXI4 RAM slave (FIXED/INCR/WRAP bursts, byte strobes, SLVERR out of range, optional hex preload); ports: clk, reset, s_axi_aw*/w*/b* write channels, s_axi_ar*/r* read channels
module axi4_ram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int DEPTH = 4096,
  parameter INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB = $clog2(BYTES);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  w_state_t w_state;
  r_state_t r_state;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [7:0] wlen, wcnt, rlen, rcnt;
  logic [1:0] wburst, rburst;
  logic werr, we, unused_wlast;
  assign unused_wlast = s_axi_wlast;
  function automatic logic inr(input logic [ADDR_WIDTH-1:0] a);
    return (a >> LSB) < ADDR_WIDTH'(DEPTH);
  endfunction
  function automatic logic [IW-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    return a[LSB +: IW];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] rword(input logic [ADDR_WIDTH-1:0] a);
    return inr(a) ? mem[idx(a)] : '0;
  endfunction
  // WRAP keeps the bits above the (len+1)*BYTES window and wraps the offset inside it
  function automatic logic [ADDR_WIDTH-1:0] nxt(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len, input logic [1:0] b);
    logic [ADDR_WIDTH-1:0] m, s;
    m = ADDR_WIDTH'(({24'd0, len} + 32'd1) * 32'(BYTES) - 32'd1);
    s = a + ADDR_WIDTH'(BYTES);
    return b == 2'd0 ? a :
           (b == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ? (a & ~m) | (s & m) : s;
  endfunction
  assign we = !reset && w_state == W_DATA && s_axi_wvalid && s_axi_wready && inr(waddr);
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < BYTES; i++)
        if (s_axi_wstrb[i]) mem[idx(waddr)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
  always_ff @(posedge clk)
    if (reset) begin
      w_state <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= 2'd0;
      s_axi_bid <= '0;
    end else
      case (w_state)
        W_IDLE:
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            s_axi_wready <= 1'b1;
            s_axi_bid <= s_axi_awid;
            waddr <= s_axi_awaddr;
            wlen <= s_axi_awlen;
            wburst <= s_axi_awburst;
            wcnt <= 8'd0;
            werr <= 1'b0;
            w_state <= W_DATA;
          end else s_axi_awready <= 1'b1;
        W_DATA:
          if (s_axi_wvalid) begin
            waddr <= nxt(waddr, wlen, wburst);
            wcnt <= wcnt + 8'd1;
            if (!inr(waddr)) werr <= 1'b1;
            if (wcnt == wlen) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp <= (werr || !inr(waddr)) ? 2'd2 : 2'd0;
              w_state <= W_RESP;
            end
          end
        W_RESP:
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state <= W_IDLE;
          end
        default: w_state <= W_IDLE;
      endcase
  // raddr always holds the address of the beat to load on the next handshake
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'd0;
      s_axi_rlast <= 1'b0;
      s_axi_rid <= '0;
    end else
      case (r_state)
        R_IDLE:
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rid <= s_axi_arid;
            s_axi_rvalid <= 1'b1;
            s_axi_rdata <= rword(s_axi_araddr);
            s_axi_rresp <= inr(s_axi_araddr) ? 2'd0 : 2'd2;
            s_axi_rlast <= s_axi_arlen == 8'd0;
            rlen <= s_axi_arlen;
            rburst <= s_axi_arburst;
            rcnt <= 8'd0;
            raddr <= nxt(s_axi_araddr, s_axi_arlen, s_axi_arburst);
            r_state <= R_DATA;
          end else s_axi_arready <= 1'b1;
        R_DATA:
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid <= 1'b0;
              s_axi_rlast <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              s_axi_rdata <= rword(raddr);
              s_axi_rresp <= inr(raddr) ? 2'd0 : 2'd2;
              s_axi_rlast <= rcnt + 8'd1 == rlen;
              rcnt <= rcnt + 8'd1;
              raddr <= nxt(raddr, rlen, rburst);
            end
          end
        default: r_state <= R_IDLE;
      endcase
endmodule

// File: tb/tb_axi4_ram_slave.sv
// tb_axi4_ram_slave: directed and randomized bursts against an array model of the RAM
module tb_axi4_ram_slave;
  localparam int DEPTH = 256;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0] awlen = '0, arlen = '0;
  logic [1:0] awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0] wstrb = '0;
  logic wlast = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  int checks = 0, errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] wd [256];
  logic [3:0] ws [256];
  logic [31:0] got [$];
  logic [31:0] keep, d [4];
  always #5 clk = ~clk;
  axi4_ram_slave #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );
  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", nm, obs, exp);
    end
  endtask
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int b, input int i);
    int sz, base;
    sz = (len + 1) * 4;
    if (b == 0) return a;
    if (b == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      base = int'(a) / sz * sz;
      return 32'(base + (int'(a) - base + i * 4) % sz);
    end
    return a + 32'(i * 4);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic hs_wait(input string nm, input bit is_ar);
    int n = 0;
    bit h;
    do begin
      h = is_ar ? arready : awready;
      tick();
      n++;
    end while (!h && n < 100);
    chk(nm, 32'(h), 32'd1);
  endtask
  task automatic wr(input logic [3:0] id, input logic [31:0] a, input int len, input int b);
    int n;
    bit h, err = 0;
    logic [31:0] ad;
    awid = id; awaddr = a; awlen = 8'(len); awburst = 2'(b); awvalid = 1'b1;
    hs_wait("aw_handshake", 1'b0);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        tick();
      end
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == len); wvalid = 1'b1;
      n = 0;
      do begin
        h = wready;
        tick();
        n++;
      end while (!h && n < 100);
      if (!h) chk("w_timeout", 32'(h), 32'd1);
      ad = beat_addr(a, len, b, i);
      if (ad / 4 < DEPTH) begin
        for (int k = 0; k < 4; k++)
          if (ws[i][k]) model[ad / 4][8*k +: 8] = wd[i][8*k +: 8];
      end else err = 1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    n = 0;
    while (!bvalid && n < 100) begin
      tick();
      n++;
    end
    chk("bvalid", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), err ? 32'd2 : 32'd0);
    chk("bid", 32'(bid), 32'(id));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_clear", 32'(bvalid), 32'd0);
  endtask
  task automatic rd(input logic [3:0] id, input logic [31:0] a, input int len, input int b, input int mode);
    int i = 0, n = 0;
    bit stall = 0;
    logic [31:0] held, ad;
    got.delete();
    arid = id; araddr = a; arlen = 8'(len); arburst = 2'(b); arvalid = 1'b1;
    hs_wait("ar_handshake", 1'b1);
    arvalid = 1'b0;
    chk("r_latency", 32'(rvalid), 32'd1);
    while (i <= len && n < 2000) begin
      rready = mode == 0 ? 1'b1 : mode == 1 ? 1'(n % 2 == 0) : 1'($urandom_range(0, 1));
      if (stall && rvalid) chk("r_stable", rdata, held);
      if (rvalid && rready) begin
        ad = beat_addr(a, len, b, i);
        chk("rdata", rdata, ad / 4 < DEPTH ? model[ad / 4] : 32'd0);
        chk("rresp", 32'(rresp), ad / 4 < DEPTH ? 32'd0 : 32'd2);
        chk("rlast", 32'(rlast), 32'(i == len));
        chk("rid", 32'(rid), 32'(id));
        got.push_back(rdata);
        i++;
        stall = 0;
      end else if (rvalid) begin
        stall = 1;
        held = rdata;
      end
      tick();
      n++;
    end
    rready = 1'b0;
    if (i <= len) chk("r_timeout", 32'(i), 32'(len + 1));
    chk("rvalid_clear", 32'(rvalid), 32'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_resp", 32'({bresp, rresp}), 0);
    chk("rst_ids", 32'({bid, rid}), 0);
    reset = 1'b0;
    tick();
    chk("awready_after_rst", 32'(awready), 1);
    chk("arready_after_rst", 32'(arready), 1);
    for (int i = 0; i < 256; i++) begin
      wd[i] = 32'd0;
      ws[i] = 4'hF;
    end
    wr(4'd1, 32'h0, 255, 1);
    wd[0] = 32'hDEADBEEF;
    wr(4'd2, 32'h10, 0, 1);
    rd(4'd3, 32'h10, 0, 1, 0);
    chk("deadbeef", got[0], 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    wr(4'd4, 32'h20, 3, 1);
    rd(4'd5, 32'h20, 3, 1, 1);
    for (int i = 0; i < 4; i++) chk("incr_order", got[i], 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      wd[i] = d[i];
    end
    wr(4'd6, 32'h38, 3, 2);
    rd(4'd7, 32'h38, 3, 2, 2);
    rd(4'd7, 32'h30, 3, 1, 0);
    chk("wrap_0x30", got[0], d[2]);
    chk("wrap_0x34", got[1], d[3]);
    chk("wrap_0x38", got[2], d[0]);
    chk("wrap_0x3c", got[3], d[1]);
    wd[0] = 32'hFFFFFFFF;
    wr(4'd8, 32'h40, 0, 1);
    wd[0] = 32'h11223344;
    ws[0] = 4'b0101;
    wr(4'd8, 32'h40, 0, 1);
    ws[0] = 4'hF;
    rd(4'd9, 32'h40, 0, 1, 0);
    chk("strobe_merge", got[0], 32'hFF22FF44);
    keep = model[0];
    wd[0] = 32'hA5A5A5A5;
    wr(4'hA, DEPTH * 4, 0, 1);
    chk("oor_bresp", 32'(bresp), 32'd2);
    rd(4'hB, DEPTH * 4, 0, 1, 0);
    chk("oor_rresp", 32'(rresp), 32'd2);
    chk("oor_rdata", got[0], 32'd0);
    rd(4'hC, 32'h0, 0, 1, 0);
    chk("word0_kept", got[0], keep);
    arid = 4'hD; araddr = 32'h0; arlen = 8'd7; arburst = 2'd1; arvalid = 1'b1;
    hs_wait("ar_handshake", 1'b1);
    arvalid = 1'b0;
    rready = 1'b1;
    tick();
    tick();
    chk("rvalid_beat2", 32'(rvalid), 32'd1);
    reset = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_in_rst", 32'(rvalid), 32'd0);
    chk("arready_in_rst", 32'(arready), 32'd0);
    reset = 1'b0;
    tick();
    chk("arready_release", 32'(arready), 32'd1);
    rd(4'hE, 32'h20, 3, 1, 0);
    for (int t = 0; t < 40; t++) begin
      int len, b;
      b = $urandom_range(0, 2);
      len = b == 2 && $urandom_range(0, 3) != 0 ? (1 << $urandom_range(1, 4)) - 1 : $urandom_range(0, 15);
      for (int i = 0; i <= len; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'($urandom);
      end
      wr(4'($urandom), 32'($urandom_range(0, DEPTH + 16) * 4), len, b);
      b = $urandom_range(0, 2);
      len = $urandom_range(0, 15);
      rd(4'($urandom), 32'($urandom_range(0, DEPTH + 16) * 4), len, b, $urandom_range(0, 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
